// File: rtl/spi_slave_rx_tx_if.sv
// Pin and core-side bundle for the SPI slave front end.
// With SPI_ABORT_FLAG_EN defined the bundle also carries frame_abort and abort_cnt.
interface spi_slave_rx_tx_if;
  logic       sclk;
  logic       cs_n;
  logic       mosi;
  logic       miso;
  logic [7:0] rx_data;
  logic       rx_rdy;
  logic [7:0] tx_data;
  logic       tx_latch;
  logic       frame_active;
`ifdef SPI_ABORT_FLAG_EN
  logic       frame_abort;
  logic [7:0] abort_cnt;
`endif

  modport slave (
    input  sclk, cs_n, mosi, tx_data, tx_latch,
`ifdef SPI_ABORT_FLAG_EN
    output frame_abort, abort_cnt,
`endif
    output miso, rx_data, rx_rdy, frame_active
  );

  modport master (
    output sclk, cs_n, mosi, tx_data, tx_latch,
`ifdef SPI_ABORT_FLAG_EN
    input  frame_abort, abort_cnt,
`endif
    input  miso, rx_data, rx_rdy, frame_active
  );
endinterface

// File: rtl/spi_slave_rx_tx.sv
// SPI mode 0 slave (MSB first), oversampled on sys_clk, feeding the core command FSM.
// Optional SPI_ABORT_FLAG_EN adds a partial-byte abort pulse and a saturating abort counter.
module spi_slave_rx_tx #(
  parameter int         SYNC_STAGES  = 2,
  parameter logic [7:0] TX_RESET_VAL = 8'h00
) (
  input logic             sys_clk,
  input logic             rst,
  spi_slave_rx_tx_if.slave bus
);

  typedef enum logic [1:0] {WAIT_IDLE, IDLE, SHIFT} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sclkSync_q, csSync_q, mosiSync_q;
  logic                   sclkPrev_q;
  logic [6:0]             rxShift_q, rxShift_d;
  logic [7:0]             txShift_q, txShift_d;
  logic [7:0]             txBuf_q, txBuf_d;
  logic [7:0]             rxData_q, rxData_d;
  logic                   rxRdy_q, rxRdy_d;
  logic [2:0]             bitCnt_q, bitCnt_d;
  logic                   sclkS, csS, mosiS, sclkRise, sclkFall;
  logic [7:0]             reloadVal;
`ifdef SPI_ABORT_FLAG_EN
  logic                   abort_q, abort_d;
  logic [7:0]             abortCnt_q, abortCnt_d;
`endif

  // cs_n sync resets low so a frame already in progress at reset release
  // is not mistaken for an idle bus.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      sclkSync_q <= '0;
      csSync_q   <= '0;
      mosiSync_q <= '0;
      sclkPrev_q <= 1'b0;
    end else begin
      sclkSync_q <= {sclkSync_q[SYNC_STAGES-2:0], bus.sclk};
      csSync_q   <= {csSync_q[SYNC_STAGES-2:0], bus.cs_n};
      mosiSync_q <= {mosiSync_q[SYNC_STAGES-2:0], bus.mosi};
      sclkPrev_q <= sclkS;
    end
  end

  assign sclkS     = sclkSync_q[SYNC_STAGES-1];
  assign csS       = csSync_q[SYNC_STAGES-1];
  assign mosiS     = mosiSync_q[SYNC_STAGES-1];
  assign sclkRise  = sclkS & ~sclkPrev_q;
  assign sclkFall  = ~sclkS & sclkPrev_q;
  assign reloadVal = bus.tx_latch ? bus.tx_data : txBuf_q;

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_q    <= WAIT_IDLE;
      rxShift_q  <= '0;
      txShift_q  <= '0;
      txBuf_q    <= TX_RESET_VAL;
      rxData_q   <= '0;
      rxRdy_q    <= 1'b0;
      bitCnt_q   <= '0;
`ifdef SPI_ABORT_FLAG_EN
      abort_q    <= 1'b0;
      abortCnt_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      rxShift_q  <= rxShift_d;
      txShift_q  <= txShift_d;
      txBuf_q    <= txBuf_d;
      rxData_q   <= rxData_d;
      rxRdy_q    <= rxRdy_d;
      bitCnt_q   <= bitCnt_d;
`ifdef SPI_ABORT_FLAG_EN
      abort_q    <= abort_d;
      abortCnt_q <= abortCnt_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    rxShift_d = rxShift_q;
    txShift_d = txShift_q;
    txBuf_d   = reloadVal;
    rxData_d  = rxData_q;
    rxRdy_d   = 1'b0;
    bitCnt_d  = bitCnt_q;
`ifdef SPI_ABORT_FLAG_EN
    abort_d    = 1'b0;
    abortCnt_d = abortCnt_q;
`endif
    case (state_q)
      WAIT_IDLE: begin
        if (csS) state_d = IDLE;
      end
      IDLE: begin
        if (!csS) begin
          state_d   = SHIFT;
          txShift_d = reloadVal;
          bitCnt_d  = '0;
        end
      end
      SHIFT: begin
        // Deselect takes priority over any sclk edge seen in the same cycle.
        if (csS) begin
          state_d  = IDLE;
          bitCnt_d = '0;
`ifdef SPI_ABORT_FLAG_EN
          if (bitCnt_q != 3'd0) begin
            abort_d    = 1'b1;
            abortCnt_d = (abortCnt_q != 8'hFF) ? abortCnt_q + 8'd1 : abortCnt_q;
          end
`endif
        end else if (sclkRise) begin
          rxShift_d = {rxShift_q[5:0], mosiS};
          if (bitCnt_q == 3'd7) begin
            rxData_d  = {rxShift_q, mosiS};
            rxRdy_d   = 1'b1;
            bitCnt_d  = '0;
            txShift_d = reloadVal;
          end else begin
            bitCnt_d = bitCnt_q + 3'd1;
          end
        end else if (sclkFall && bitCnt_q != 3'd0) begin
          txShift_d = {txShift_q[6:0], 1'b0};
        end
      end
      default: state_d = WAIT_IDLE;
    endcase
  end

  assign bus.frame_active = (state_q == SHIFT);
  assign bus.miso         = bus.frame_active & txShift_q[7];
  assign bus.rx_data      = rxData_q;
  assign bus.rx_rdy       = rxRdy_q;
`ifdef SPI_ABORT_FLAG_EN
  assign bus.frame_abort  = abort_q;
  assign bus.abort_cnt    = abortCnt_q;
`endif

endmodule
